// File: rtl/fetch_pkg.sv
// Purpose: shared widths, FSM encoding and FIFO entry layout for the fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int ADDR_W  = 27;
  localparam int INSTR_W = 32;

  // Fetch FSM encoding
  localparam logic [1:0] FS_IDLE    = 2'd0;
  localparam logic [1:0] FS_WAIT    = 2'd1;
  localparam logic [1:0] FS_DISCARD = 2'd2;

  // One prefetch slot: the word and the address it was read from
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Purpose: synchronous FIFO with a clear input, head data visible straight from storage.
// Latency: a push is visible at the head one cycle later when the FIFO was empty.
// Backpressure: none internally; the caller must only push when not full and pop when not empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 59,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push && !clear && !reset) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; clear wins over a same-cycle push/pop
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Purpose: sequences word reads over a start/done bus and buffers them for decode; redirects on flush.
// Latency: bus_done at edge N shows the word on instr at N+1 when the queue was empty.
// Backpressure: a new read is issued only while the prefetch FIFO has room; decode stalls via instr_ready.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 27'd0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_start,
  input  logic                bus_done,
  input  logic [INSTR_W-1:0]  bus_q,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   flush_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // A returning word is kept only for a live request; flush drops both enqueue and dequeue
  assign push        = (state == FS_WAIT) && bus_done && !flush;
  assign pop         = instr_valid && instr_ready && !flush;
  assign push_entry  = '{pc: bus_addr, word: bus_q};
  assign instr_valid = (count != '0);
  assign instr       = head_entry.word;
  assign instr_pc    = head_entry.pc;

  // Occupancy after this cycle's enqueue/dequeue, used to decide on back-to-back reissue
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (count)
  );

  // Fetch FSM: issue, await completion, or drain a stale read after a redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FS_IDLE;
      fetch_pc  <= RESET_PC;
      bus_start <= 1'b0;
      bus_addr  <= RESET_PC;
    end else begin
      bus_start <= 1'b0;
      case (state)
        FS_IDLE: begin
          if (flush) begin
            fetch_pc <= flush_pc;
          end else if (count < DEPTH_C) begin
            bus_start <= 1'b1;
            bus_addr  <= fetch_pc;
            state     <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (flush) begin
            fetch_pc <= flush_pc;
            state    <= bus_done ? FS_IDLE : FS_DISCARD;
          end else if (bus_done) begin
            fetch_pc <= next_addr(bus_addr);
            if (count_next < DEPTH_C) begin
              bus_start <= 1'b1;
              bus_addr  <= next_addr(bus_addr);
            end else begin
              state <= FS_IDLE;
            end
          end
        end
        FS_DISCARD: begin
          if (flush)    fetch_pc <= flush_pc;
          if (bus_done) state    <= FS_IDLE;
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Purpose: directed, self-checking bench for the fetch queue (table vectors plus corner sequences).
// Latency: inputs applied 1 time unit after a rising edge, outputs checked 1 unit after the next.
// Backpressure: instr_ready driven directly by the stimulus.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        bus_done;
  logic [31:0] bus_q;
  logic        instr_ready;
  logic        flush;
  logic [26:0] flush_pc;

  logic [26:0] bus_addr, bus_addr2;
  logic        bus_start, bus_start2;
  logic [31:0] instr, instr2;
  logic [26:0] instr_pc, instr_pc2;
  logic        instr_valid, instr_valid2;

  int checks = 0;
  int errors = 0;
  bit auto_bus = 0;
  int delay = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(27'd0)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_start(bus_start),
    .bus_done(bus_done), .bus_q(bus_q), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush), .flush_pc(flush_pc)
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(27'h7FFFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .bus_addr(bus_addr2), .bus_start(bus_start2),
    .bus_done(bus_done), .bus_q(bus_q), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready), .flush(flush), .flush_pc(flush_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock; in auto mode a memory answers every bus_start two edges later
  task automatic tick();
    if (auto_bus) begin
      bus_done = 1'b0;
      if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          bus_done = 1'b1;
          bus_q    = 32'h2000_0000 | {5'd0, bus_addr};
        end
      end
    end
    @(posedge clk);
    #1;
    if (auto_bus && bus_start) delay = 2;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus_done = 1'b0; flush = 1'b0; delay = 0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        done;
    logic [31:0] q;
    logic        rdy;
    logic        e_start;
    logic [26:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [26:0] e_pc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [26:0] wexp[3];
    int n_s, n_v, starts;
    logic [26:0] last_addr;

    reset = 1'b1; bus_done = 1'b0; bus_q = '0; instr_ready = 1'b0;
    flush = 1'b0; flush_pc = '0;

    // Basic streaming: done two edges after every start, decoder always ready
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 27'd0, 1'b0, 32'h0,         27'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 27'd0, 1'b0, 32'h0,         27'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 27'd0, 1'b0, 32'h0,         27'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'h1000_0001, 1'b1, 1'b1, 27'd1, 1'b1, 32'h1000_0001, 27'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 27'd1, 1'b0, 32'h0,         27'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'h1000_0002, 1'b1, 1'b1, 27'd2, 1'b1, 32'h1000_0002, 27'd1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 27'd2, 1'b0, 32'h0,         27'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'h1000_0003, 1'b1, 1'b1, 27'd3, 1'b1, 32'h1000_0003, 27'd2};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 27'd3, 1'b0, 32'h0,         27'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'h1000_0004, 1'b1, 1'b1, 27'd4, 1'b1, 32'h1000_0004, 27'd3};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 27'd4, 1'b0, 32'h0,         27'd0};

    for (int i = 0; i < 11; i++) begin
      reset = vecs[i].rst; bus_done = vecs[i].done; bus_q = vecs[i].q;
      instr_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d_start", i), bus_start, vecs[i].e_start);
      chk($sformatf("v%0d_addr", i), bus_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), instr_valid, vecs[i].e_vld);
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
        chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].e_pc);
      end
    end

    // Backpressure: queue fills with exactly DEPTH requests, then one slot frees
    auto_bus = 0; instr_ready = 1'b0;
    do_reset();
    auto_bus = 1; starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_start) begin
        chk($sformatf("fill_addr%0d", starts), bus_addr, starts);
        starts++;
      end
    end
    chk("fill_starts", starts, 4);
    chk("fill_valid", instr_valid, 1'b1);
    chk("fill_head_pc", instr_pc, 27'd0);
    chk("fill_head_instr", instr, 32'h2000_0000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("pop_head_pc", instr_pc, 27'd1);
    starts = 0; last_addr = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_start) begin
        starts++;
        last_addr = bus_addr;
      end
    end
    chk("refill_starts", starts, 1);
    chk("refill_addr", last_addr, 27'd4);
    auto_bus = 0; bus_done = 1'b0;

    // Flush while a request is outstanding; stale word must be drained and dropped
    instr_ready = 1'b0;
    do_reset();
    tick();
    chk("fl_first_start", bus_start, 1'b1);
    tick();
    bus_done = 1'b1; bus_q = 32'h1111_1111;
    tick();
    bus_done = 1'b0;
    chk("fl_pre_valid", instr_valid, 1'b1);
    chk("fl_pre_instr", instr, 32'h1111_1111);
    flush = 1'b1; flush_pc = 27'h100;
    tick();
    flush = 1'b0;
    chk("fl_valid_n1", instr_valid, 1'b0);
    chk("fl_start_n1", bus_start, 1'b0);
    tick();
    chk("fl_valid_n2", instr_valid, 1'b0);
    bus_done = 1'b1; bus_q = 32'hDEAD_BEEF;
    tick();
    bus_done = 1'b0;
    chk("fl_stale_valid", instr_valid, 1'b0);
    chk("fl_stale_start", bus_start, 1'b0);
    tick();
    chk("fl_restart", bus_start, 1'b1);
    chk("fl_restart_addr", bus_addr, 27'h100);
    chk("fl_restart_valid", instr_valid, 1'b0);
    tick();
    bus_done = 1'b1; bus_q = 32'h1234_5678;
    tick();
    bus_done = 1'b0;
    chk("fl_new_valid", instr_valid, 1'b1);
    chk("fl_new_instr", instr, 32'h1234_5678);
    chk("fl_new_pc", instr_pc, 27'h100);

    // Flush in the same cycle as bus_done: word dropped, FIFO emptied
    tick();
    bus_done = 1'b1; bus_q = 32'hCAFE_F00D; flush = 1'b1; flush_pc = 27'h200;
    tick();
    bus_done = 1'b0; flush = 1'b0;
    chk("fd_valid", instr_valid, 1'b0);
    chk("fd_start", bus_start, 1'b0);
    tick();
    chk("fd_restart", bus_start, 1'b1);
    chk("fd_restart_addr", bus_addr, 27'h200);
    chk("fd_valid2", instr_valid, 1'b0);

    // Address wrap at the top of the 27-bit space
    instr_ready = 1'b1;
    do_reset();
    auto_bus = 1;
    wexp[0] = 27'h7FFFFFE; wexp[1] = 27'h7FFFFFF; wexp[2] = 27'h0000000;
    n_s = 0; n_v = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_start2 && n_s < 3) begin
        chk($sformatf("wrap_addr%0d", n_s), bus_addr2, wexp[n_s]);
        n_s++;
      end
      if (instr_valid2 && n_v < 3) begin
        chk($sformatf("wrap_pc%0d", n_v), instr_pc2, wexp[n_v]);
        n_v++;
      end
    end
    chk("wrap_starts", n_s, 3);
    chk("wrap_words", n_v, 3);
    auto_bus = 0; bus_done = 1'b0;

    // Reset mid-request, then a late bus_done for the abandoned read
    instr_ready = 1'b0;
    do_reset();
    tick();
    chk("rw_start", bus_start, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_reset_start", bus_start, 1'b0);
    chk("rw_reset_addr", bus_addr, 27'd0);
    bus_done = 1'b1; bus_q = 32'hBADB_AD00;
    tick();
    bus_done = 1'b0;
    chk("rw_late_start", bus_start, 1'b1);
    chk("rw_late_addr", bus_addr, 27'd0);
    chk("rw_late_valid", instr_valid, 1'b0);
    tick();
    chk("rw_late_valid2", instr_valid, 1'b0);
    bus_done = 1'b1; bus_q = 32'h0000_0055;
    tick();
    bus_done = 1'b0;
    chk("rw_word_valid", instr_valid, 1'b1);
    chk("rw_word_instr", instr, 32'h0000_0055);
    chk("rw_word_pc", instr_pc, 27'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
